// File: rtl/vga_csc_pkg.sv
// Shared types and constants for the colour-space output stage.
// Coefficient rows are ordered {Pr, Y, Pb}; columns are {R, G, B}, signed Q1.10.
package vga_csc_pkg;

    typedef enum logic [1:0] {
        CSC_RGB = 2'b00,
        CSC_601 = 2'b01,
        CSC_709 = 2'b10
    } csc_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } csc_st_e;

    typedef logic signed [10:0] coef_t;

    typedef struct packed {
        coef_t [2:0][2:0] m;
    } csc_coef_t;

    localparam csc_coef_t COEF_601 = '{m: {
        11'sd450, -11'sd377, -11'sd73,
        11'sd263,  11'sd516,  11'sd100,
        -11'sd152, -11'sd298,  11'sd450}};

    localparam csc_coef_t COEF_709 = '{m: {
        11'sd450, -11'sd409, -11'sd41,
        11'sd187,  11'sd629,  11'sd63,
        -11'sd103, -11'sd347,  11'sd450}};

    // Limits and offsets for 8-bit channels; wider channels shift these up.
    localparam int Y_OFF = 16;
    localparam int C_OFF = 128;
    localparam int Y_LO  = 16;
    localparam int Y_HI  = 235;
    localparam int C_LO  = 16;
    localparam int C_HI  = 240;

endpackage

// File: rtl/vga_csc_if.sv
// Video stream bundle: sync, data enable and one packed pixel.
interface vga_csc_if #(
    parameter int DW = 8
);
    logic            hsync;
    logic            vsync;
    logic            csync;
    logic            de;
    logic [3*DW-1:0] data;

    modport master (output hsync, vsync, csync, de, data);
    modport slave  (input  hsync, vsync, csync, de, data);
endinterface

// File: rtl/vga_csc_mac.sv
// One output channel: multiply (S1), sum + offset + round (S2), clamp/select (S3).
// The raw RGB channel rides alongside so RGB mode and blanking resolve in S3.
module vga_csc_mac
    import vga_csc_pkg::*;
#(
    parameter int DW   = 8,
    parameter bit IS_Y = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [2:0][10:0]     coef,
    input  logic [2:0][DW-1:0]   chan,
    input  logic [DW-1:0]        pass,
    input  logic                 rgb,
    input  logic                 de,
    output logic [DW-1:0]        dout
);
    localparam int PW    = DW + 12;
    localparam int ACC_W = DW + 16;
    localparam int SC    = DW - 8;
    localparam int OFF_I = (IS_Y ? Y_OFF : C_OFF) << SC;
    localparam int LO_I  = (IS_Y ? Y_LO : C_LO) << SC;
    localparam int HI_I  = (IS_Y ? Y_HI : C_HI) << SC;
    localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(OFF_I * 1024 + 512);
    localparam logic signed [ACC_W-1:0] LO   = ACC_W'(LO_I);
    localparam logic signed [ACC_W-1:0] HI   = ACC_W'(HI_I);

    logic signed [PW-1:0]    prod_d [3];
    logic signed [PW-1:0]    prod_q [3];
    logic [DW+1:0]           s1_d, s1_q, s2_d, s2_q;
    logic signed [ACC_W-1:0] acc_d, acc_q, val;
    logic [DW-1:0]           dout_d, dout_q;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            prod_d[k] = ce ? $signed(coef[k]) * $signed({1'b0, chan[k]}) : prod_q[k];
        end
        s1_d  = ce ? {rgb, de, pass} : s1_q;
        s2_d  = ce ? s1_q : s2_q;
        acc_d = ce ? ACC_W'(prod_q[0]) + ACC_W'(prod_q[1]) + ACC_W'(prod_q[2]) + BIAS : acc_q;

        val    = acc_q >>> 10;
        dout_d = dout_q;
        if (ce) begin
            if (s2_q[DW+1])       dout_d = s2_q[DW-1:0];
            else if (!s2_q[DW])   dout_d = DW'(OFF_I);
            else if (val < LO)    dout_d = DW'(LO_I);
            else if (val > HI)    dout_d = DW'(HI_I);
            else                  dout_d = val[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) prod_q[k] <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            for (int k = 0; k < 3; k++) prod_q[k] <= prod_d[k];
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/vga_csc_out.sv
// RGB -> YPbPr (BT.601/709) or pass-through output stage, 3 pixel-enable cycles of latency.
// Mode changes are deferred to the vsync leading edge so a frame is never mixed.
module vga_csc_out
    import vga_csc_pkg::*;
#(
    parameter int DW     = 8,
    parameter bit VS_POL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [1:0] mode,
    vga_csc_if.slave   vin,
    vga_csc_if.master  vout,
    output logic [1:0] mode_act
);
    csc_st_e    state_d, state_q;
    csc_mode_e  mode_act_d, mode_act_q, req;
    logic       vs_prev_d, vs_prev_q, fedge;
    logic [2:0][3:0] sync_pipe_d, sync_pipe_q;
    csc_coef_t  coef_sel;
    logic [2:0][DW-1:0] rgb_in, dout_w;

    assign req   = (mode == 2'b11) ? CSC_RGB : csc_mode_e'(mode);
    assign fedge = (vs_prev_q != VS_POL) && (vin.vsync == VS_POL);

    always_comb begin
        state_d     = state_q;
        mode_act_d  = mode_act_q;
        vs_prev_d   = vs_prev_q;
        sync_pipe_d = sync_pipe_q;
        if (ce_pix) begin
            vs_prev_d   = vin.vsync;
            sync_pipe_d = {sync_pipe_q[1:0], {vin.hsync, vin.vsync, vin.csync, vin.de}};
            case (state_q)
                ST_IDLE: if (req != mode_act_q) begin
                    // A request landing on the edge cycle itself is applied immediately.
                    if (fedge) mode_act_d = req;
                    else       state_d    = ST_PEND;
                end
                ST_PEND: if (fedge) begin
                    mode_act_d = req;
                    state_d    = ST_IDLE;
                end else if (req == mode_act_q) begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_act_q  <= CSC_RGB;
            vs_prev_q   <= 1'b0;
            sync_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_act_q  <= mode_act_d;
            vs_prev_q   <= vs_prev_d;
            sync_pipe_q <= sync_pipe_d;
        end
    end

    assign coef_sel = (mode_act_q == CSC_709) ? COEF_709 : COEF_601;
    assign rgb_in   = vin.data;

    // Lane 2 = Pr / R, lane 1 = Y / G, lane 0 = Pb / B.
    for (genvar i = 0; i < 3; i++) begin : g_lane
        vga_csc_mac #(.DW(DW), .IS_Y(i == 1)) u_mac (
            .clk   (clk),
            .reset (reset),
            .ce    (ce_pix),
            .coef  (coef_sel.m[i]),
            .chan  (rgb_in),
            .pass  (rgb_in[i]),
            .rgb   (mode_act_q == CSC_RGB),
            .de    (vin.de),
            .dout  (dout_w[i])
        );
    end

    assign vout.data  = dout_w;
    assign vout.hsync = sync_pipe_q[2][3];
    assign vout.vsync = sync_pipe_q[2][2];
    assign vout.csync = sync_pipe_q[2][1];
    assign vout.de    = sync_pipe_q[2][0];
    assign mode_act   = mode_act_q;
endmodule

// File: tb/tb_vga_csc_out.sv
// Directed bench for vga_csc_out at DW=8: conversion values, latency, frame-boundary mode switch,
// pixel-enable stalls, blanking and reset.
module tb_vga_csc_out;
    logic       clk = 1'b0;
    logic       reset, ce_pix;
    logic [1:0] mode, mode_act;
    int         n_chk = 0;
    int         n_fail = 0;

    vga_csc_if #(.DW(8)) vin_if ();
    vga_csc_if #(.DW(8)) vout_if ();

    vga_csc_out #(.DW(8), .VS_POL(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .mode     (mode),
        .vin      (vin_if),
        .vout     (vout_if),
        .mode_act (mode_act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [23:0] d, input logic de, input logic hs);
        vin_if.data  = d;
        vin_if.de    = de;
        vin_if.hsync = hs;
    endtask

    // Request a mode and produce a vsync rising edge so it is applied.
    task automatic set_mode(input logic [1:0] m);
        mode = m;
        vin_if.vsync = 1'b0;
        step(1);
        vin_if.vsync = 1'b1;
        step(1);
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b1; mode = 2'b00;
        vin_if.vsync = 1'b0; vin_if.csync = 1'b0;
        pix(24'h0, 1'b0, 1'b0);
        step(2);
        chk("rst_dout", 32'(vout_if.data), 32'h0);
        chk("rst_de", 32'(vout_if.de), 32'h0);
        chk("rst_mode", 32'(mode_act), 32'h0);
        reset = 1'b0;

        // BT.601 white/black/red and exact 3-cycle latency
        set_mode(2'b01);
        chk("m601", 32'(mode_act), 32'h1);
        pix(24'hFFFFFF, 1'b1, 1'b0); step(3);
        chk("601_white", 32'(vout_if.data), 32'h80EB80);
        pix(24'h000000, 1'b1, 1'b0); step(2);
        chk("lat_hold", 32'(vout_if.data), 32'h80EB80);
        step(1);
        chk("601_black", 32'(vout_if.data), 32'h801080);
        pix(24'hFF0000, 1'b1, 1'b0); step(3);
        chk("601_red", 32'(vout_if.data), 32'hF0515A);

        // Pixel enable toggling 1010...
        pix(24'h0, 1'b0, 1'b0); step(3);
        pix(24'hFFFFFF, 1'b1, 1'b1); step(1);
        ce_pix = 1'b0; pix(24'h123456, 1'b1, 1'b1); step(1);
        ce_pix = 1'b1; pix(24'h0, 1'b0, 1'b0); step(1);
        ce_pix = 1'b0; step(1);
        chk("ce_early", 32'(vout_if.data), 32'h801080);
        chk("ce_early_hs", 32'(vout_if.hsync), 32'h0);
        ce_pix = 1'b1; step(1);
        chk("ce_out", 32'(vout_if.data), 32'h80EB80);
        chk("ce_out_hs", 32'(vout_if.hsync), 32'h1);
        chk("ce_out_de", 32'(vout_if.de), 32'h1);
        ce_pix = 1'b0; pix(24'hFFFFFF, 1'b1, 1'b1); step(1);
        chk("ce_hold", 32'(vout_if.data), 32'h80EB80);
        chk("ce_hold_hs", 32'(vout_if.hsync), 32'h1);
        ce_pix = 1'b1; pix(24'h0, 1'b0, 1'b0); step(1);
        chk("ce_next", 32'(vout_if.data), 32'h801080);
        chk("ce_next_hs", 32'(vout_if.hsync), 32'h0);

        // BT.709, blanking, reserved mode maps to RGB
        set_mode(2'b10);
        chk("m709", 32'(mode_act), 32'h2);
        pix(24'hFFFFFF, 1'b0, 1'b0); step(3);
        chk("709_blank", 32'(vout_if.data), 32'h801080);
        pix(24'hFF0000, 1'b1, 1'b0); step(3);
        chk("709_red", 32'(vout_if.data), 32'hF03F66);
        set_mode(2'b11);
        chk("m11", 32'(mode_act), 32'h0);
        pix(24'hFFFFFF, 1'b0, 1'b0); step(3);
        chk("rgb_blank", 32'(vout_if.data), 32'hFFFFFF);

        // Mid-frame request waits for the vsync edge
        vin_if.vsync = 1'b0; step(1);
        mode = 2'b01; pix(24'h123456, 1'b1, 1'b0); step(3);
        chk("pend_mode", 32'(mode_act), 32'h0);
        chk("pend_dout", 32'(vout_if.data), 32'h123456);
        vin_if.vsync = 1'b1; pix(24'hFF0000, 1'b1, 1'b0); step(1);
        chk("edge_mode", 32'(mode_act), 32'h1);
        pix(24'hFFFFFF, 1'b1, 1'b0); step(2);
        chk("edge_old_px", 32'(vout_if.data), 32'hFF0000);
        step(1);
        chk("edge_new_px", 32'(vout_if.data), 32'h80EB80);

        // Reset mid-line with a pending change
        set_mode(2'b00);
        vin_if.vsync = 1'b0; vin_if.csync = 1'b1; mode = 2'b01;
        pix(24'hFFFFFF, 1'b1, 1'b1); step(3);
        reset = 1'b1; step(1);
        chk("mrst_dout", 32'(vout_if.data), 32'h0);
        chk("mrst_sync", 32'({vout_if.hsync, vout_if.csync, vout_if.de}), 32'h0);
        chk("mrst_mode", 32'(mode_act), 32'h0);
        reset = 1'b0; mode = 2'b00; step(1);
        vin_if.vsync = 1'b1; step(1);
        chk("mrst_noswitch", 32'(mode_act), 32'h0);
        vin_if.vsync = 1'b0; mode = 2'b01; step(1);
        vin_if.vsync = 1'b1; step(1);
        chk("mrst_switch", 32'(mode_act), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
